// File: rtl/string_match_ctrl_pkg.sv
// Shared types for the string-match controller: FSM states, flagged-string layout, slot-length rules.
package string_ctrl_pkg;

    localparam int unsigned MAX_STRLEN = 17;
    localparam int unsigned STRLEN_W   = 5;

    // Byte 0 is the first character of the flagged string.
    typedef logic [0:MAX_STRLEN-1][7:0] flagged_str_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_REPORT,
        ST_CLEAR
    } ctrl_state_e;

    function automatic logic strlen_valid(input logic [STRLEN_W-1:0] len);
        return (len != '0) && (len <= STRLEN_W'(MAX_STRLEN));
    endfunction

endpackage

// File: rtl/string_match_ctrl_slot_table.sv
// Flagged-string slot storage with a single write port and a per-slot enable mask.
module string_slot_table
    import string_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STR = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               wr_en_i,
    input  logic [IDX_W-1:0]                   wr_idx_i,
    input  flagged_str_t                       wr_string_i,
    input  logic [STRLEN_W-1:0]                wr_strlen_i,
    output flagged_str_t [NUM_STR-1:0]         str_o,
    output logic [NUM_STR-1:0][STRLEN_W-1:0]   strlen_o,
    output logic [NUM_STR-1:0]                 en_mask_o
);

    flagged_str_t [NUM_STR-1:0]       str_q, str_d;
    logic [NUM_STR-1:0][STRLEN_W-1:0] len_q, len_d;

    always_comb begin
        str_d = str_q;
        len_d = len_q;
        for (int unsigned i = 0; i < NUM_STR; i++) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                str_d[i] = wr_string_i;
                len_d[i] = wr_strlen_i;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            str_q <= '0;
            len_q <= '0;
        end else begin
            str_q <= str_d;
            len_q <= len_d;
        end
    end

    always_comb begin
        en_mask_o = '0;
        for (int unsigned i = 0; i < NUM_STR; i++) begin
            en_mask_o[i] = strlen_valid(len_q[i]);
        end
    end

    assign str_o    = str_q;
    assign strlen_o = len_q;

endmodule

// File: rtl/string_match_ctrl.sv
// Packet-framed feed/collect controller for a bank of string comparators.
// Optional per-slot saturating hit counters: define STRING_HIT_COUNTERS_EN.
module string_match_ctrl
    import string_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_STR  = 4,
    parameter  int unsigned PIPE_LAT = 5,
    localparam int unsigned IDX_W    = (NUM_STR > 1) ? $clog2(NUM_STR) : 1
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [31:0]                       data_in,
    input  logic                              data_valid,
    input  logic                              sop,
    input  logic                              eop,
    output logic                              in_ready,
    input  logic                              cfg_wr_en,
    input  logic [IDX_W-1:0]                  cfg_idx,
    input  flagged_str_t                      cfg_string,
    input  logic [STRLEN_W-1:0]               cfg_strlen,
    output logic                              cfg_err,
    output logic [31:0]                       cmp_data_in,
    output logic                              cmp_clear,
    output flagged_str_t [NUM_STR-1:0]        cmp_flagged_string,
    output logic [NUM_STR-1:0][STRLEN_W-1:0]  cmp_strlen,
    input  logic [NUM_STR-1:0]                cmp_match,
    output logic                              result_valid,
    output logic [NUM_STR-1:0]                result_mask
`ifdef STRING_HIT_COUNTERS_EN
    ,
    output logic [NUM_STR-1:0][15:0]          hit_count
`endif
);

    localparam int unsigned CNT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    ctrl_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_STR-1:0] hit_q, hit_d;
    logic               cfg_err_q, cfg_err_d;
    logic [NUM_STR-1:0] en_mask;
    logic               accept;
    logic               cfg_ok;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_STREAM);
    assign accept   = data_valid && in_ready;

    // Any word taken in IDLE, even a dropped non-sop word, blocks the slot write.
    assign cfg_ok    = cfg_wr_en && (state_q == ST_IDLE) && !accept;
    assign cfg_err_d = cfg_wr_en && !cfg_ok;
    assign cfg_err   = cfg_err_q;

    string_slot_table #(
        .NUM_STR (NUM_STR),
        .IDX_W   (IDX_W)
    ) u_slots (
        .clk         (clk),
        .n_rst       (n_rst),
        .wr_en_i     (cfg_ok),
        .wr_idx_i    (cfg_idx),
        .wr_string_i (cfg_string),
        .wr_strlen_i (cfg_strlen),
        .str_o       (cmp_flagged_string),
        .strlen_o    (cmp_strlen),
        .en_mask_o   (en_mask)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        cmp_data_in  = '0;
        result_valid = 1'b0;
        result_mask  = '0;
        cmp_clear    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && sop) begin
                    cmp_data_in = data_in;
                    if (eop) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_W'(PIPE_LAT);
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                hit_d = hit_q | cmp_match;
                if (accept) begin
                    cmp_data_in = data_in;
                    if (eop) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_W'(PIPE_LAT);
                    end
                end
            end
            ST_DRAIN: begin
                hit_d = hit_q | cmp_match;
                if (cnt_q == '0) begin
                    state_d = ST_REPORT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_REPORT: begin
                result_valid = 1'b1;
                result_mask  = hit_q & en_mask;
                state_d      = ST_CLEAR;
            end
            ST_CLEAR: begin
                cmp_clear = 1'b1;
                hit_d     = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hit_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef STRING_HIT_COUNTERS_EN
    logic [NUM_STR-1:0][15:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        for (int unsigned i = 0; i < NUM_STR; i++) begin
            if (result_valid && result_mask[i] && (hit_cnt_q[i] != 16'hFFFF)) begin
                hit_cnt_d[i] = hit_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_count = hit_cnt_q;
`endif

endmodule

// File: tb/tb_string_match_ctrl.sv
// Directed bench for string_match_ctrl; the comparator bank is emulated by driving cmp_match.
module tb_string_match_ctrl;
    import string_ctrl_pkg::*;

    localparam int NUM_STR  = 4;
    localparam int PIPE_LAT = 5;

    logic                              clk = 1'b0;
    logic                              n_rst;
    logic [31:0]                       data_in;
    logic                              data_valid, sop, eop;
    logic                              in_ready;
    logic                              cfg_wr_en;
    logic [1:0]                        cfg_idx;
    flagged_str_t                      cfg_string;
    logic [4:0]                        cfg_strlen;
    logic                              cfg_err;
    logic [31:0]                       cmp_data_in;
    logic                              cmp_clear;
    flagged_str_t [NUM_STR-1:0]        cmp_flagged_string;
    logic [NUM_STR-1:0][4:0]           cmp_strlen;
    logic [NUM_STR-1:0]                cmp_match;
    logic                              result_valid;
    logic [NUM_STR-1:0]                result_mask;
`ifdef STRING_HIT_COUNTERS_EN
    logic [NUM_STR-1:0][15:0]          hit_count;
    int                                exp_hits [NUM_STR];
`endif

    int          n_chk = 0;
    int          n_bad = 0;
    int          rv_cnt = 0;
    int          exp_rv = 0;
    logic [31:0] pkt_w [8];

    string_match_ctrl #(
        .NUM_STR  (NUM_STR),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .data_in            (data_in),
        .data_valid         (data_valid),
        .sop                (sop),
        .eop                (eop),
        .in_ready           (in_ready),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_idx            (cfg_idx),
        .cfg_string         (cfg_string),
        .cfg_strlen         (cfg_strlen),
        .cfg_err            (cfg_err),
        .cmp_data_in        (cmp_data_in),
        .cmp_clear          (cmp_clear),
        .cmp_flagged_string (cmp_flagged_string),
        .cmp_strlen         (cmp_strlen),
        .cmp_match          (cmp_match),
        .result_valid       (result_valid),
        .result_mask        (result_mask)
`ifdef STRING_HIT_COUNTERS_EN
        ,
        .hit_count          (hit_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) rv_cnt++;
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic flagged_str_t mk_str(input string s);
        flagged_str_t v = '0;
        for (int i = 0; i < s.len() && i < 17; i++) v[i] = s[i];
        return v;
    endfunction

    // Called just after a posedge; returns just after a posedge.
    task automatic cfg_write(input logic [1:0] idx, input string s, input logic [4:0] len);
        cfg_wr_en = 1'b1; cfg_idx = idx; cfg_string = mk_str(s); cfg_strlen = len;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        @(negedge clk);
        check("cfg_err_ok", cfg_err, 1'b0);
        check("cfg_len", cmp_strlen[idx], len);
        check("cfg_str", cmp_flagged_string[idx], mk_str(s));
        @(posedge clk); #1;
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1; data_in = pkt_w[i]; sop = (i == 0); eop = (i == n - 1);
            @(negedge clk);
            check("in_ready_rx", in_ready, 1'b1);
            check("cmp_data", cmp_data_in, pkt_w[i]);
            @(posedge clk); #1;
        end
        data_valid = 1'b0; sop = 1'b0; eop = 1'b0; data_in = '0;
    endtask

    // match is presented by the emulated comparators for one cycle, dly cycles into the drain.
    task automatic wait_report(input string tag, input logic [3:0] match, input int dly,
                               input logic [3:0] exp_mask, input int exp_lat);
        bit          got = 0;
        int          lat = 0;
        logic [3:0]  m = '0;
        cmp_match = (dly == 0) ? match : '0;
        for (int k = 1; k <= 30 && !got; k++) begin
            @(posedge clk); #1;
            cmp_match = (k == dly) ? match : '0;
            @(negedge clk);
            if (result_valid) begin got = 1; lat = k; m = result_mask; end
        end
        cmp_match = '0;
        if (!got) begin
            check({tag, "_timeout"}, 1'b0, 1'b1);
        end else begin
            exp_rv++;
`ifdef STRING_HIT_COUNTERS_EN
            for (int i = 0; i < NUM_STR; i++) if (exp_mask[i]) exp_hits[i]++;
`endif
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_mask"}, m, exp_mask);
            check({tag, "_in_ready_rep"}, in_ready, 1'b0);
            @(negedge clk);
            check({tag, "_rv_once"}, result_valid, 1'b0);
            check({tag, "_clear"}, cmp_clear, 1'b1);
            @(negedge clk);
            check({tag, "_clear_once"}, cmp_clear, 1'b0);
            check({tag, "_idle"}, in_ready, 1'b1);
        end
        @(posedge clk); #1;
    endtask

    task automatic load_google(input logic [31:0] w3);
        pkt_w[0] = "www."; pkt_w[1] = "goog"; pkt_w[2] = "le.c"; pkt_w[3] = w3;
    endtask

    initial begin
        n_rst = 1'b0; data_in = '0; data_valid = 0; sop = 0; eop = 0;
        cfg_wr_en = 0; cfg_idx = '0; cfg_string = '0; cfg_strlen = '0; cmp_match = '0;
`ifdef STRING_HIT_COUNTERS_EN
        for (int i = 0; i < NUM_STR; i++) exp_hits[i] = 0;
`endif
        #2;
        check("rst_rv", result_valid, 1'b0);
        check("rst_mask", result_mask, '0);
        check("rst_clear", cmp_clear, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_strlen", cmp_strlen, '0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        // Basic match on slot 0
        cfg_write(2'd0, "www.google.com", 5'd14);
        load_google("om  ");
        send_words(4);
        wait_report("google", 4'b0001, 2, 4'b0001, PIPE_LAT + 1);

        // Single sop&eop word matching slot 1
        cfg_write(2'd1, "abc", 5'd3);
        pkt_w[0] = " abc";
        send_words(1);
        wait_report("abc", 4'b0010, 3, 4'b0010, PIPE_LAT + 1);

        // Near-miss packet: no comparator fires
        pkt_w[0] = "www."; pkt_w[1] = "goog"; pkt_w[2] = "book"; pkt_w[3] = ".com";
        send_words(4);
        wait_report("nomatch", 4'b0001, -1, 4'b0000, PIPE_LAT + 1);

        // Sticky hit: match at first and at last drain cycle
        load_google("om  ");
        send_words(4);
        wait_report("sticky_first", 4'b0001, 0, 4'b0001, PIPE_LAT + 1);
        send_words(4);
        wait_report("sticky_last", 4'b0001, PIPE_LAT, 4'b0001, PIPE_LAT + 1);

        // Word without sop in IDLE is dropped and blocks a same-cycle config write
        data_valid = 1; data_in = 32'h1122_3344; sop = 0; eop = 0;
        cfg_wr_en = 1; cfg_idx = 2'd3; cfg_string = mk_str("zzzzz"); cfg_strlen = 5'd5;
        @(negedge clk);
        check("drop_cmp_data", cmp_data_in, 32'h0);
        @(posedge clk); #1;
        data_valid = 0; data_in = '0; cfg_wr_en = 0;
        @(negedge clk);
        check("collide_cfg_err", cfg_err, 1'b1);
        check("collide_len", cmp_strlen[3], 5'd0);
        check("drop_idle", in_ready, 1'b1);
        @(negedge clk);
        check("collide_err_once", cfg_err, 1'b0);
        @(posedge clk); #1;

        // Config write during STREAM, then a word offered during DRAIN
        data_valid = 1; sop = 1; eop = 0; data_in = "www.";
        @(posedge clk); #1;
        sop = 0; data_in = "goog";
        cfg_wr_en = 1; cfg_idx = 2'd2; cfg_string = mk_str("xyz"); cfg_strlen = 5'd3;
        @(posedge clk); #1;
        cfg_wr_en = 0; data_in = "le.c"; eop = 1;
        @(negedge clk);
        check("stream_cfg_err", cfg_err, 1'b1);
        check("stream_cfg_len", cmp_strlen[2], 5'd0);
        @(posedge clk); #1;
        data_valid = 1; sop = 1; eop = 1; data_in = 32'hDEAD_BEEF;
        @(negedge clk);
        check("drain_in_ready", in_ready, 1'b0);
        check("drain_cmp_data", cmp_data_in, 32'h0);
        check("stream_err_once", cfg_err, 1'b0);
        @(posedge clk); #1;
        data_valid = 0; sop = 0; eop = 0; data_in = '0;
        wait_report("drain_ignore", 4'b0000, 1, 4'b0000, PIPE_LAT);

`ifdef STRING_HIT_COUNTERS_EN
        for (int i = 0; i < NUM_STR; i++) check("hit_count", hit_count[i], exp_hits[i]);
`endif

        // Enable-mask boundaries: strlen 17 enabled, 18 and 0 disabled
        cfg_write(2'd2, "abcdefghijklmnopq", 5'd17);
        cfg_write(2'd3, "x", 5'd18);
        load_google("om  ");
        send_words(4);
        wait_report("len18", 4'b1111, 1, 4'b0111, PIPE_LAT + 1);
        cfg_write(2'd3, "", 5'd0);
        send_words(4);
        wait_report("len0", 4'b1111, 4, 4'b0111, PIPE_LAT + 1);

        // Reset in the middle of a packet
        data_valid = 1; sop = 1; eop = 0; data_in = "www.";
        @(posedge clk); #1;
        sop = 0; data_in = "goog";
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_idle", in_ready, 1'b1);
        check("mid_rst_rv", result_valid, 1'b0);
        check("mid_rst_clear", cmp_clear, 1'b0);
        check("mid_rst_cfg_err", cfg_err, 1'b0);
        check("mid_rst_mask", result_mask, '0);
        check("mid_rst_cmp_data", cmp_data_in, 32'h0);
        check("mid_rst_strlen", cmp_strlen, '0);
        check("mid_rst_str", cmp_flagged_string, '0);
`ifdef STRING_HIT_COUNTERS_EN
        check("mid_rst_hits", hit_count, '0);
        for (int i = 0; i < NUM_STR; i++) exp_hits[i] = 0;
`endif
        data_valid = 0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        cfg_write(2'd0, "www.google.com", 5'd14);
        load_google("om  ");
        send_words(4);
        wait_report("post_rst", 4'b0001, 3, 4'b0001, PIPE_LAT + 1);
`ifdef STRING_HIT_COUNTERS_EN
        for (int i = 0; i < NUM_STR; i++) check("hit_count_post", hit_count[i], exp_hits[i]);
`endif

        repeat (3) @(posedge clk);
        check("rv_count", rv_cnt, exp_rv);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
